// File: rtl/defs.sv
// Shared types for the fetch/data memory arbiter: FSM states and grant owner.
package defs;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} mem_arb_state_t;
  typedef enum logic {OWN_IF, OWN_D} mem_owner_t;
endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store.
// Data wins by default; a saturating starvation counter forces a fetch grant.
module mem_arbiter
  import defs::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_kill,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_wstrb,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

  mem_arb_state_t state_q, state_d;
  mem_owner_t     owner_q, owner_d;
  logic [SW-1:0]  starve_q, starve_d;
  logic           kill_q, kill_d;
  logic           mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [3:0]     mem_wstrb_q, mem_wstrb_d;
  logic [31:0]    mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic           if_ready_q, if_ready_d, d_ready_q, d_ready_d;
  logic [31:0]    if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;

  function automatic mem_owner_t pick(input logic ifr, input logic dr,
                                      input logic [SW-1:0] cnt);
    if (ifr && (!dr || cnt == LIM)) return OWN_IF;
    return OWN_D;
  endfunction

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    kill_d      = kill_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (!if_req) starve_d = '0;
        if (if_req || d_req) begin
          state_d   = BUSY;
          mem_req_d = 1'b1;
          if (pick(if_req, d_req, starve_q) == OWN_IF) begin
            owner_d     = OWN_IF;
            mem_addr_d  = if_addr;
            mem_we_d    = 1'b0;
            mem_wstrb_d = 4'h0;
            mem_wdata_d = '0;
            starve_d    = '0;
          end else begin
            owner_d     = OWN_D;
            mem_addr_d  = d_addr;
            mem_we_d    = d_we;
            mem_wstrb_d = d_wstrb;
            mem_wdata_d = d_wdata;
            if (if_req && starve_q != LIM) starve_d = starve_q + SW'(1);
          end
        end
      end
      BUSY: begin
        if (if_kill && owner_q == OWN_IF) kill_d = 1'b1;
        // Ready is raised on the ack edge so it is visible during RESP.
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
          if (owner_q == OWN_IF) begin
            if_rdata_d = mem_rdata;
            if_ready_d = !(kill_q || if_kill);
          end else begin
            d_rdata_d = mem_rdata;
            d_ready_d = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        kill_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_D;
      starve_q    <= '0;
      kill_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wstrb_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      kill_q      <= kill_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ready  = if_ready_q;
  assign if_rdata  = if_rdata_q;
  assign d_ready   = d_ready_q;
  assign d_rdata   = d_rdata_q;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one single-ported unified memory between the instruction-fetch port (stage 1) and the load/store port (stage 4) of the 5-stage pipeline. Data accesses win by default; a starvation counter guarantees fetch progress. The block registers each granted request, holds it on the memory bus until acknowledged, and returns a one-cycle `ready` pulse with read data to the winner. `if_ready` drives the pipeline's `instr_ready` input.

## Interface
- `STARVE_LIMIT`, 4: consecutive data grants made while fetch waits before fetch is forced to win; must be ≥1.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `if_req`  in  1  fetch request, level, held until `if_ready`.
- `if_addr`  in  32  fetch address, stable while `if_req`.
- `if_kill`  in  1  pipeline flush; discards any in-flight fetch result.
- `if_ready`  out  1  one-cycle pulse, `if_rdata` valid.
- `if_rdata`  out  32  fetched instruction.
- `d_req`  in  1  data request, level, held until `d_ready`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_wstrb`  in  4  byte enables for stores.
- `d_addr`, `d_wdata`  in  32 each  data address / store data.
- `d_ready`  out  1  one-cycle pulse, access complete.
- `d_rdata`  out  32  load data, valid with `d_ready`.
- `mem_req`  out  1  memory request, held until `mem_ack`.
- `mem_we`  out  1; `mem_wstrb`  out  4; `mem_addr`, `mem_wdata`  out  32 each.
- `mem_ack`  in  1  memory completion; sampled only while `mem_req`=1.
- `mem_rdata`  in  32  valid with `mem_ack`.

## Operation
- FSM states: IDLE, BUSY, RESP. Register `owner` ∈ {IF, D} records the winner.
- IDLE: if any request is pending, arbitrate, latch the winner's addr/we/wstrb/wdata into the `mem_*` registers, set `mem_req`, and go to BUSY. Otherwise stay in IDLE.
- Priority: D wins unless `if_req` is high and `starve_cnt == STARVE_LIMIT`, in which case IF wins.
- `starve_cnt` (width $clog2(STARVE_LIMIT+1)): increments on a D grant while `if_req` is high. It clears on an IF grant, and clears in any IDLE cycle in which `if_req` is low. It saturates at `STARVE_LIMIT`.
- Fetch grants drive `mem_we`=0 and `mem_wstrb`=0.
- BUSY: `mem_*` outputs stay stable. On `mem_ack`: capture `mem_rdata` into the owner's rdata register, drop `mem_req`, go to RESP.
- RESP: pulse the owner's `ready` for exactly one cycle, then return to IDLE. No arbitration takes place in RESP, so a request still asserted during the ready cycle cannot be granted twice.
- Kill handling:
  - `if_kill` in IDLE: no effect.
  - `if_kill` in BUSY with owner = IF: set `kill_pend`. The memory transaction still completes, but the RESP cycle suppresses `if_ready`. `kill_pend` clears on leaving RESP.
  - `if_kill` during RESP: no effect; the pulse is emitted and the pipeline discards it.
- Non-owner `ready` and `rdata` hold their previous values.

## Timing
- Reset values: state = IDLE, all `mem_*` = 0, `if_ready` = `d_ready` = 0, both rdata registers = 0, `starve_cnt` = 0, `kill_pend` = 0.
- Reset mid-transaction: `mem_req` drops on the next edge. A later `mem_ack` for the aborted access is ignored; the memory must tolerate the abandoned request.
- Latency: request seen in IDLE at cycle T → `mem_req` high at T+1 → earliest `mem_ack` at T+1 → `ready` at T+2 → IDLE at T+3. Minimum 3 cycles per access, so peak throughput is one access every 3 cycles.
- All outputs are registered; there is no combinational path from any input to any output.
- Simultaneous `if_req` and `d_req` in IDLE: exactly one grant per the priority rule. The loser stays pending and is arbitrated in the next IDLE.

## Structure
- Shared package `defs`: enum `mem_arb_state_t` {IDLE, BUSY, RESP} and enum `mem_owner_t` {OWN_IF, OWN_D}.
- No sub-module. The priority decision is a local function.

## Test plan
- Fetch only: `if_req`, `if_addr`=0x100, ack one cycle after `mem_req` → `mem_addr`=0x100, `mem_we`=0, `if_ready` pulse with `if_rdata`=`mem_rdata`=0x00000013 exactly 2 cycles after grant.
- Conflict: both requests in the same cycle, store 0xDEADBEEF to 0x200 with wstrb 0xF → D is served first, then IF. `d_ready` and `if_ready` never high in the same cycle.
- Starvation: `d_req` held continuously with `if_req` high → after 4 D grants the 5th grant goes to IF; `starve_cnt` returns to 0 afterwards.
- Kill: fetch in BUSY, `if_kill` pulsed, ack 3 cycles later → `mem_req` drops on ack and no `if_ready` pulse occurs. The next fetch completes normally.
- Wait states: `mem_ack` delayed 5 cycles → `mem_addr`, `mem_wdata`, `mem_wstrb` are unchanged throughout, and exactly one `ready` pulse follows.
- Reset in BUSY → next cycle all outputs are 0 and state is IDLE; a stale `mem_ack` produces no `ready`.
